// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg
//   Shared definitions for the async FIFO stream adapters.
//   - buf_state_e : occupancy state of the 2-entry output buffer. The
//                   encoding equals the occupancy count, so it can drive a
//                   level output directly. The write-side adapter uses the
//                   same encoding.
//   - DATAWIDTH_DEF / CNTW_DEF : default data and counter widths, shared
//                   with the FIFO top level.
package fifo_rd_stream_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } buf_state_e;

    localparam int unsigned DATAWIDTH_DEF = 8;
    localparam int unsigned CNTW_DEF      = 16;

endpackage

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side adapter for the async FIFO, in the rclk domain. It turns the
//   FIFO's rinc/rempty/rdata port into a registered valid/ready stream
//   through a 2-entry buffer (head + skid), which keeps one word per cycle
//   of throughput while the FIFO pop request never depends on m_ready.
//
// Ports
//   rclk, rrst_n     read clock, asynchronous active-low reset
//   rempty, rdata    FIFO status and combinational read data
//   rinc             FIFO pop request
//   flush            synchronous buffer clear (FIFO contents untouched)
//   m_valid, m_data  output stream, head-of-buffer word
//   m_ready          consumer accepts the head word this cycle
//   level            buffer occupancy, 0..2
//   rd_count         words delivered, modulo 2^cntw (not cleared by flush)
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned datawidth = DATAWIDTH_DEF,
    parameter int unsigned cntw      = CNTW_DEF
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 rempty,
    input  logic [datawidth-1:0] rdata,
    output logic                 rinc,
    input  logic                 flush,
    output logic                 m_valid,
    output logic [datawidth-1:0] m_data,
    input  logic                 m_ready,
    output logic [1:0]           level,
    output logic [cntw-1:0]      rd_count
);

    buf_state_e           state;
    logic [datawidth-1:0] skid;
    logic                 push;
    logic                 pop;

    // The pop request looks only at registered state, rempty and flush, so
    // the consumer's m_ready never reaches the FIFO read pointer logic.
    // rrst_n forces it low while reset is held.
    always_comb begin
        rinc = rrst_n & ~rempty & ~flush & (state != ST_TWO);
        push = rinc;
        pop  = m_valid & m_ready & ~flush;
    end

    // State encoding equals occupancy.
    assign level = state;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state   <= ST_EMPTY;
            m_valid <= 1'b0;
            m_data  <= '0;
            skid    <= '0;
        end else if (flush) begin
            state   <= ST_EMPTY;
            m_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state   <= ST_ONE;
                        m_valid <= 1'b1;
                        m_data  <= rdata;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state <= ST_TWO;
                        skid  <= rdata;
                    end else if (push && pop) begin
                        m_data <= rdata;
                    end else if (!push && pop) begin
                        state   <= ST_EMPTY;
                        m_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    // rinc is low here, so only a pop can move the state.
                    if (pop) begin
                        state  <= ST_ONE;
                        m_data <= skid;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + cntw'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream. The FIFO is modelled as a queue of words;
// a scoreboard queue holds words taken from the FIFO but not yet delivered.
// Inputs are driven 1ns after the rising edge; the monitor checks outputs
// on the falling edge and then advances the model.
module tb_fifo_rd_stream;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;

    logic          rclk;
    logic          rrst_n;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          flush;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [1:0]    level;
    logic [CW-1:0] rd_count;

    fifo_rd_stream #(.datawidth(DW), .cntw(CW)) dut (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .rempty   (rempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .level    (level),
        .rd_count (rd_count)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    logic [DW-1:0] fifo_q[$];   // FIFO contents, head at index 0
    logic [DW-1:0] exp_q[$];    // words in the adapter, oldest first
    logic [CW-1:0] cnt_model;
    bit            pending_pop;
    bit            mon_en;
    int            n_cmp;
    int            n_err;
    int            cyc;
    int            first_pop_cyc;
    int            last_pop_cyc;
    int            n_pops_phase;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic drive_fifo();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? '0 : fifo_q[0];
    endtask

    // Advance one cycle; apply the FIFO pop the monitor recorded.
    task automatic step();
        @(posedge rclk);
        #1;
        if (pending_pop) begin
            void'(fifo_q.pop_front());
            pending_pop = 1'b0;
        end
        drive_fifo();
    endtask

    task automatic wait_level(input int lv, input int budget, input string name);
        int n;
        n = 0;
        while (int'(level) != lv && n < budget) begin
            step();
            n++;
        end
        check(name, int'(level), lv);
    endtask

    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        m_ready = 1'b1;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || pending_pop) && n < budget) begin
            step();
            n++;
        end
        check(name, exp_q.size() + fifo_q.size(), 0);
    endtask

    // Monitor / scoreboard: check outputs against the model, then apply the
    // effects of the coming rising edge to the model.
    always @(negedge rclk) begin
        cyc++;
        if (rrst_n && mon_en) begin
            check("m_valid", int'(m_valid), int'(exp_q.size() != 0));
            check("level", int'(level), exp_q.size());
            check("rd_count", int'(rd_count), int'(cnt_model));
            // The adapter requests a word exactly when one is available,
            // there is room for it and no flush is in progress.
            check("rinc", int'(rinc),
                  int'(fifo_q.size() != 0 && !flush && exp_q.size() < 2));
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_valid && m_ready) begin
                    if (exp_q.size() != 0) begin
                        check("m_data", int'(m_data), int'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                    cnt_model = cnt_model + 1'b1;
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    n_pops_phase++;
                end
                if (rinc && fifo_q.size() != 0) begin
                    exp_q.push_back(fifo_q[0]);
                    pending_pop = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] saved_cnt;
        int            produced;
        int            n;

        n_cmp = 0; n_err = 0; cyc = 0;
        cnt_model = '0; pending_pop = 1'b0; mon_en = 1'b0;
        first_pop_cyc = -1; last_pop_cyc = -1; n_pops_phase = 0;
        rrst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;

        // Reset with a non-empty FIFO holding A5, 3C.
        fifo_q.push_back(8'hA5);
        fifo_q.push_back(8'h3C);
        drive_fifo();
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_rinc", int'(rinc), 0);
        end
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_level", int'(level), 0);
        rrst_n = 1'b1;
        #1;
        check("rel_rinc", int'(rinc), 1);
        check("rel_m_valid", int'(m_valid), 0);
        check("rel_level", int'(level), 0);
        check("rel_rd_count", int'(rd_count), 0);
        check("rel_m_data", int'(m_data), 0);
        mon_en = 1'b1;

        // Backpressure: both words taken, then rinc stays low.
        for (int i = 0; i < 4; i++) step();
        check("bp_level", int'(level), 2);
        check("bp_rinc", int'(rinc), 0);
        check("bp_m_data", int'(m_data), 8'hA5);
        m_ready = 1'b1;
        step();
        check("bp_m_data2", int'(m_data), 8'h3C);
        check("bp_level2", int'(level), 1);
        step();
        check("bp_level3", int'(level), 0);
        check("bp_rd_count", int'(rd_count), 2);

        // Full-rate stream 00..FF; rd_count wraps at 8 bits.
        for (int i = 0; i < 256; i++) fifo_q.push_back(DW'(i));
        drive_fifo();
        first_pop_cyc = -1; n_pops_phase = 0;
        drain(600, "stream_drain");
        check("stream_pops", n_pops_phase, 256);
        check("stream_no_gaps", last_pop_cyc - first_pop_cyc, 255);
        check("stream_rd_count", int'(rd_count), 2);

        // Random producer and random m_ready over 1000 words.
        produced = 0; n = 0; n_pops_phase = 0;
        while (produced < 1000 && n < 20000) begin
            if ($urandom_range(0, 99) < 55) begin
                fifo_q.push_back(DW'($urandom));
                produced++;
            end
            drive_fifo();
            m_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        drain(3000, "rand_drain");
        check("rand_pops", n_pops_phase, 1000);

        // Flush while holding 11, 22.
        m_ready = 1'b0;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        drive_fifo();
        wait_level(2, 10, "fl_level2");
        fifo_q.push_back(8'h33);
        drive_fifo();
        saved_cnt = rd_count;
        flush = 1'b1;
        m_ready = 1'b1;
        #1;
        check("fl_rinc", int'(rinc), 0);
        step();
        flush = 1'b0;
        m_ready = 1'b0;
        check("fl_m_valid", int'(m_valid), 0);
        check("fl_level", int'(level), 0);
        check("fl_rd_count", int'(rd_count), int'(saved_cnt));
        step();
        check("fl_next_valid", int'(m_valid), 1);
        check("fl_next_data", int'(m_data), 8'h33);
        drain(20, "fl_drain");

        // Asynchronous reset mid-stream in state ONE.
        m_ready = 1'b0;
        fifo_q.push_back(8'h44);
        drive_fifo();
        wait_level(1, 10, "ar_level1");
        #2;
        mon_en = 1'b0;
        rrst_n = 1'b0;
        fifo_q.push_back(8'h55);
        drive_fifo();
        #1;
        check("ar_m_valid", int'(m_valid), 0);
        check("ar_level", int'(level), 0);
        check("ar_rd_count", int'(rd_count), 0);
        check("ar_rinc", int'(rinc), 0);
        exp_q.delete();
        cnt_model = '0;
        pending_pop = 1'b0;
        step();
        rrst_n = 1'b1;
        #1;
        mon_en = 1'b1;
        step();
        check("ar_restart_data", int'(m_data), 8'h55);
        drain(20, "ar_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
